// File: rtl/op_frame_sequencer_pkg.sv
// Package warmup_pkg: shared types for the op_frame_sequencer block.
//  - seq_state_t : sequencer FSM states
//  - err_code_t  : error codes reported on err_code
//  - SYNC_BYTE_DEF, OP_W_DEF, op_t : default frame marker and opcode type
package warmup_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         OP_W_DEF      = 2;

  typedef logic [OP_W_DEF-1:0] op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP  = 3'd1,
    GET_A   = 3'd2,
    GET_B   = 3'd3,
    GET_CHK = 3'd4,
    ISSUE   = 3'd5,
    WAIT    = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_BAD_OP  = 3'd1,
    ERR_BAD_CHK = 3'd2,
    ERR_RX_TMO  = 3'd3,
    ERR_PU_TMO  = 3'd4,
    ERR_OVERRUN = 3'd5
  } err_code_t;

endpackage

// File: rtl/op_frame_sequencer_seq_timer.sv
// seq_timer: watchdog counter.
//  clk, rst : clock, synchronous active-high reset
//  clr      : zero the count (wins over en)
//  en       : count while high
//  expired  : one-cycle pulse when the count sits at LIMIT-1 while enabled;
//             the count wraps to 0 so a lingering en cannot re-fire at once
module seq_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // A clear in the same cycle means a fresh event arrived, so no expiry.
    expired = en && !clr && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clr)          cnt_d = '0;
    else if (expired) cnt_d = '0;
    else if (en)      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/op_frame_sequencer.sv
// op_frame_sequencer: parses SYNC,OP,A,B,CHK frames from the rx byte stream
// and issues one validated operation to the PU, then holds its result.
//  rx_ready/rx_data           : byte strobe from the UART receiver
//  pu_ready/pu_start          : start handshake (start held until accepted)
//  data_a/data_b/operation    : operands, stable except when entering ISSUE
//  pu_done/pu_result/pu_overflow : PU completion
//  result_data/overflow       : last completed result (held)
//  result_valid               : pulse when result_data updates
//  busy                       : FSM not in IDLE
//  err_valid/err_code         : error pulse and its code
module op_frame_sequencer
  import warmup_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                OP_W       = 2,
  parameter int                NUM_OPS    = 4,
  parameter logic [DATA_W-1:0] SYNC_BYTE  = DATA_W'(SYNC_BYTE_DEF),
  parameter int                RX_TIMEOUT = 50000,
  parameter int                PU_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              pu_ready,
  output logic              pu_start,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [OP_W-1:0]   operation,
  input  logic              pu_done,
  input  logic [DATA_W-1:0] pu_result,
  input  logic              pu_overflow,
  output logic [DATA_W-1:0] result_data,
  output logic              overflow,
  output logic              result_valid,
  output logic              busy,
  output logic              err_valid,
  output logic [2:0]        err_code
);

  localparam logic [DATA_W-1:0] NUM_OPS_V = DATA_W'(NUM_OPS);

  seq_state_t        state_q, state_d;
  logic [OP_W-1:0]   op_sh_q, op_sh_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [DATA_W-1:0] chk_q, chk_d;          // running OP^A^B
  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              res_vld_q, res_vld_d;
  logic              err_vld_q, err_vld_d;
  err_code_t         err_code_q, err_code_d;

  logic in_frame, accept, rx_tmo, pu_tmo;

  assign in_frame = (state_q == GET_OP) || (state_q == GET_A) ||
                    (state_q == GET_B)  || (state_q == GET_CHK);
  assign accept   = (state_q == ISSUE) && pu_ready;

  // Link watchdog: every byte restarts it, including the SYNC that enters GET_OP.
  seq_timer #(.LIMIT(RX_TIMEOUT)) u_rx_timer (
    .clk(clk), .rst(rst), .clr(rx_ready), .en(in_frame), .expired(rx_tmo)
  );

  // PU watchdog: starts from the accept edge.
  seq_timer #(.LIMIT(PU_TIMEOUT)) u_pu_timer (
    .clk(clk), .rst(rst), .clr(accept), .en(state_q == WAIT), .expired(pu_tmo)
  );

  always_comb begin
    state_d    = state_q;
    op_sh_d    = op_sh_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    chk_d      = chk_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    res_vld_d  = 1'b0;
    err_vld_d  = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (rx_ready && rx_data == SYNC_BYTE) state_d = GET_OP;
      end
      GET_OP: begin
        if (rx_ready) begin
          if (rx_data >= NUM_OPS_V) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_BAD_OP;
            state_d    = IDLE;
          end else begin
            op_sh_d = rx_data[OP_W-1:0];
            chk_d   = rx_data;
            state_d = GET_A;
          end
        end else if (rx_tmo) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_RX_TMO;
          state_d    = IDLE;
        end
      end
      GET_A, GET_B: begin
        if (rx_ready) begin
          if (state_q == GET_A) begin
            a_sh_d  = rx_data;
            state_d = GET_B;
          end else begin
            b_sh_d  = rx_data;
            state_d = GET_CHK;
          end
          chk_d = chk_q ^ rx_data;
        end else if (rx_tmo) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_RX_TMO;
          state_d    = IDLE;
        end
      end
      GET_CHK: begin
        if (rx_ready) begin
          if (rx_data != chk_q) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_BAD_CHK;
            state_d    = IDLE;
          end else begin
            // The only point where the PU-facing operands change.
            data_a_d = a_sh_q;
            data_b_d = b_sh_q;
            op_d     = op_sh_q;
            state_d  = ISSUE;
          end
        end else if (rx_tmo) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_RX_TMO;
          state_d    = IDLE;
        end
      end
      ISSUE: begin
        if (accept) state_d = WAIT;
        if (rx_ready) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end
      WAIT: begin
        // Priority: completion, then PU timeout, then overrun.
        if (pu_done) begin
          result_d  = pu_result;
          ovf_d     = pu_overflow;
          res_vld_d = 1'b1;
          state_d   = IDLE;
        end else if (pu_tmo) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_PU_TMO;
          state_d    = IDLE;
        end else if (rx_ready) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_sh_q    <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      chk_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      res_vld_q  <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      op_sh_q    <= op_sh_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      chk_q      <= chk_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      res_vld_q  <= res_vld_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
    end
  end

  assign pu_start     = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign data_a       = data_a_q;
  assign data_b       = data_b_q;
  assign operation    = op_q;
  assign result_data  = result_q;
  assign overflow     = ovf_q;
  assign result_valid = res_vld_q;
  assign err_valid    = err_vld_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_op_frame_sequencer.sv
// Bench for op_frame_sequencer: vector table of frames, hand-written corner
// sequences (timeouts, overrun, reset mid-op) and random frames checked
// against a frame-level reference model.
module tb_op_frame_sequencer;

  localparam int DATA_W = 8, OP_W = 2, NUM_OPS = 4, RX_TMO = 16, PU_TMO = 8;

  logic              clk = 1'b0, rst = 1'b1;
  logic              rx_ready = 1'b0, pu_ready = 1'b0, pu_done = 1'b0, pu_overflow = 1'b0;
  logic [DATA_W-1:0] rx_data = '0, pu_result = '0;
  logic              pu_start, overflow, result_valid, busy, err_valid;
  logic [DATA_W-1:0] data_a, data_b, result_data;
  logic [OP_W-1:0]   operation;
  logic [2:0]        err_code;

  op_frame_sequencer #(
    .DATA_W(DATA_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS), .SYNC_BYTE(8'hA5),
    .RX_TIMEOUT(RX_TMO), .PU_TIMEOUT(PU_TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .pu_ready(pu_ready), .pu_start(pu_start), .data_a(data_a), .data_b(data_b),
    .operation(operation), .pu_done(pu_done), .pu_result(pu_result),
    .pu_overflow(pu_overflow), .result_data(result_data), .overflow(overflow),
    .result_valid(result_valid), .busy(busy), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  logic [7:0]  last_res = '0;
  logic        last_ovf = 1'b0;

  typedef struct {
    logic [4:0][7:0] f;     // f[0] is the first byte on the wire
    int              n;     // bytes sent
    int              rdly;  // cycles pu_ready stays low in ISSUE
    int              ddly;  // cycles from accept to pu_done
    logic [7:0]      pres;
    logic            povf;
    int              code;  // expected error, 0 = completes
  } vec_t;

  function automatic vec_t mk(logic [7:0] b0, b1, b2, b3, b4, int n, rdly, ddly,
                              logic [7:0] pres, logic povf, int code);
    vec_t v;
    v.f = {b4, b3, b2, b1, b0};
    v.n = n; v.rdly = rdly; v.ddly = ddly; v.pres = pres; v.povf = povf; v.code = code;
    return v;
  endfunction

  // Reference PU behaviour used to make up responses for random frames.
  function automatic logic [8:0] pu_calc(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    case (op)
      2'd0: pu_calc = {1'b0, a} + {1'b0, b};
      2'd1: pu_calc = {(a < b), 8'(a - b)};
      2'd2: begin p = a * b; pu_calc = {(|p[15:8]), p[7:0]}; end
      default: pu_calc = {1'b0, a ^ b};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic accept();
    pu_ready = 1'b1;
    tick();
    pu_ready = 1'b0;
  endtask

  // Entered right after the CHK edge of a valid frame.
  task automatic finish_ok(logic [7:0] a, logic [7:0] b, logic [1:0] op, int rdly, int ddly,
                           logic [7:0] pres, logic povf);
    chk("pu_start_rise", pu_start, 1);
    chk("data_a", data_a, a);
    chk("data_b", data_b, b);
    chk("operation", operation, op);
    for (int k = 0; k < rdly; k++) begin
      tick();
      chk("pu_start_hold", pu_start, 1);
      chk("data_a_stable", data_a, a);
      chk("data_b_stable", data_b, b);
    end
    accept();
    chk("pu_start_drop", pu_start, 0);
    chk("busy_wait", busy, 1);
    repeat (ddly) tick();
    pu_done = 1'b1; pu_result = pres; pu_overflow = povf;
    tick();
    pu_done = 1'b0;
    chk("result_valid", result_valid, 1);
    chk("result_data", result_data, pres);
    chk("overflow", overflow, povf);
    last_res = pres; last_ovf = povf;
    tick();
    chk("result_valid_pulse", result_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_frame(vec_t v, int gap);
    for (int i = 0; i < v.n; i++) begin
      repeat (gap) tick();
      send_byte(v.f[i]);
    end
    if (v.code != 0) begin
      chk("err_valid", err_valid, 1);
      chk("err_code", err_code, v.code);
      chk("no_pu_start", pu_start, 0);
      tick();
      chk("err_valid_pulse", err_valid, 0);
      chk("busy_after_err", busy, 0);
      chk("result_held", result_data, last_res);
      chk("overflow_held", overflow, last_ovf);
    end else begin
      finish_ok(v.f[2], v.f[3], v.f[1][1:0], v.rdly, v.ddly, v.pres, v.povf);
    end
  endtask

  // Returns number of ticks until err_valid is seen (-1 if never within the bound).
  task automatic wait_err(output int seen, output logic [2:0] code);
    seen = -1; code = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err_valid) begin seen = k; code = err_code; break; end
    end
  endtask

  // err_valid and result_valid must never coincide.
  always @(negedge clk) begin
    if (err_valid || result_valid) begin
      checks++;
      if (err_valid && result_valid) begin
        failures++;
        $display("FAIL err_result_exclusive: both high at t=%0t", $time);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[9];

  initial begin
    int         seen;
    logic [2:0] code;
    vec_t       v;
    logic [7:0] a, b, op, cs;
    logic [8:0] r;
    bit         bad;

    vt[0] = mk(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26, 5, 0, 0, 8'h46, 1'b0, 0);
    vt[1] = mk(8'hA5, 8'h01, 8'h10, 8'h20, 8'h00, 5, 0, 0, 8'h00, 1'b0, 2);
    vt[2] = mk(8'hA5, 8'h01, 8'h10, 8'h20, 8'h31, 5, 0, 1, 8'hF0, 1'b1, 0);
    vt[3] = mk(8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 2, 0, 0, 8'h00, 1'b0, 1);
    vt[4] = mk(8'hA5, 8'h02, 8'h10, 8'h11, 8'h03, 5, 5, 2, 8'h10, 1'b1, 0);
    vt[5] = mk(8'hA5, 8'h03, 8'hF0, 8'h0F, 8'hFC, 5, 1, 0, 8'hFF, 1'b0, 0);
    vt[6] = mk(8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 2, 0, 0, 8'h00, 1'b0, 1);
    vt[7] = mk(8'hA5, 8'h00, 8'hFF, 8'h01, 8'hFE, 5, 0, 3, 8'h00, 1'b1, 0);
    vt[8] = mk(8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 5, 2, 0, 8'h4A, 1'b1, 0);

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_pu_start", pu_start, 0);
    chk("rst_result", result_data, 0);
    chk("rst_flags", {overflow, result_valid, err_valid, err_code}, 0);
    chk("rst_operands", {data_a, data_b, operation}, 0);
    rst = 1'b0;
    tick();

    // Vector table
    foreach (vt[i]) run_frame(vt[i], i % 2);

    // RX timeout after A5,00 and 16 silent cycles
    send_byte(8'hA5); send_byte(8'h00);
    wait_err(seen, code);
    chk("rx_tmo_cycle", seen, RX_TMO);
    chk("rx_tmo_code", code, 3);
    tick();
    chk("rx_tmo_busy", busy, 0);

    // A byte arriving on the expiry cycle wins and is processed
    send_byte(8'hA5); send_byte(8'h00);
    repeat (RX_TMO - 1) tick();
    send_byte(8'h12);
    chk("rx_beats_tmo_err", err_valid, 0);
    chk("rx_beats_tmo_busy", busy, 1);
    send_byte(8'h34); send_byte(8'h26);
    finish_ok(8'h12, 8'h34, 2'd0, 0, 0, 8'h46, 1'b0);

    // PU timeout: result unchanged
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    accept();
    wait_err(seen, code);
    chk("pu_tmo_cycle", seen, PU_TMO);
    chk("pu_tmo_code", code, 4);
    chk("pu_tmo_busy", busy, 0);
    chk("pu_tmo_result", result_data, last_res);

    // PU timeout and rx byte on the same cycle: only PU_TMO
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    accept();
    repeat (PU_TMO - 1) tick();
    rx_ready = 1'b1; rx_data = 8'h55;
    tick();
    rx_ready = 1'b0;
    chk("tmo_vs_ovr_code", {err_valid, err_code}, {1'b1, 3'd4});
    chk("tmo_vs_ovr_busy", busy, 0);
    tick();
    chk("tmo_vs_ovr_single", err_valid, 0);

    // pu_done on the timeout cycle: result wins
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    accept();
    repeat (PU_TMO - 1) tick();
    pu_done = 1'b1; pu_result = 8'h77; pu_overflow = 1'b0;
    tick();
    pu_done = 1'b0;
    chk("done_vs_tmo_rv", result_valid, 1);
    chk("done_vs_tmo_err", err_valid, 0);
    chk("done_vs_tmo_res", result_data, 8'h77);
    last_res = 8'h77; last_ovf = 1'b0;
    tick();
    chk("done_vs_tmo_late_err", err_valid, 0);

    // Overrun during WAIT: state stays WAIT, then completes
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    accept();
    send_byte(8'h5A);
    chk("overrun_code", {err_valid, err_code}, {1'b1, 3'd5});
    chk("overrun_busy", busy, 1);
    chk("overrun_start", pu_start, 0);
    pu_done = 1'b1; pu_result = 8'h03; pu_overflow = 1'b0;
    tick();
    pu_done = 1'b0;
    chk("overrun_then_done", {result_valid, result_data}, {1'b1, 8'h03});
    last_res = 8'h03; last_ovf = 1'b0;
    tick();

    // Reset mid-WAIT; a late pu_done is ignored
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05); send_byte(8'h06); send_byte(8'h03);
    accept();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_busy", busy, 0);
    chk("rstw_start", pu_start, 0);
    chk("rstw_outs", {result_data, overflow, data_a, data_b, operation}, 0);
    pu_done = 1'b1; pu_result = 8'hEE; pu_overflow = 1'b1;
    tick();
    pu_done = 1'b0;
    chk("rstw_no_rv", result_valid, 0);
    chk("rstw_result", result_data, 0);
    last_res = '0; last_ovf = 1'b0;

    // Garbage before SYNC is dropped
    send_byte(8'h00); send_byte(8'h12); send_byte(8'hFF);
    chk("garbage_idle", busy, 0);
    run_frame(vt[0], 0);

    // Random frames against the frame-level model
    for (int it = 0; it < 40; it++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        a = 8'($urandom);
        send_byte((a == 8'hA5) ? 8'h5A : a);
      end
      op  = 8'($urandom_range(0, 5));
      a   = 8'($urandom);
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      cs  = op ^ a ^ b ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
      r   = pu_calc(op[1:0], a, b);
      if (op >= NUM_OPS)
        v = mk(8'hA5, op, a, b, cs, 2, 0, 0, 8'h00, 1'b0, 1);
      else if (bad)
        v = mk(8'hA5, op, a, b, cs, 5, 0, 0, 8'h00, 1'b0, 2);
      else
        v = mk(8'hA5, op, a, b, cs, 5, $urandom_range(0, 3), $urandom_range(0, 4),
               r[7:0], r[8], 0);
      run_frame(v, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
